// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
// Holds the M-extension operation encoding and small decode helpers used by
// the unit to derive operand signedness and result selection from the opcode.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  // Divide-class ops occupy the upper half of the encoding.
  function automatic logic op_is_div(input muldiv_op_t o);
    return o[2];
  endfunction

  function automatic logic op_is_rem(input muldiv_op_t o);
    return (o == MD_REM) || (o == MD_REMU);
  endfunction

  function automatic logic op_is_high(input muldiv_op_t o);
    return (o == MD_MULH) || (o == MD_MULHSU) || (o == MD_MULHU);
  endfunction

  // MUL only uses the low half, so its operand signedness is irrelevant;
  // treating it as signed keeps the decode uniform.
  function automatic logic op_a_signed(input muldiv_op_t o);
    return (o == MD_MUL) || (o == MD_MULH) || (o == MD_MULHSU) ||
           (o == MD_DIV) || (o == MD_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_t o);
    return (o == MD_MUL) || (o == MD_MULH) || (o == MD_DIV) || (o == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Latency: XLEN+2 cycles (34 for word ops, 2 for divide-by-zero / overflow).
// Backpressure: stall holds upstream from accept through CALC; low in DONE/flush.
// Ports:
//   clk, reset (async active-low)   valid_in, op, word, a, b   flush
//   stall (comb)   done (one-cycle pulse)   result (held until next done)
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  muldiv_op_t      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  muldiv_op_t        op_q, op_d;
  logic              word_q, word_d;
  logic [XLEN-1:0]   ma_q, ma_d;       // |a| (N significant bits)
  logic [XLEN-1:0]   mb_q, mb_d;       // |b| (N significant bits)
  logic              qneg_q, qneg_d;   // product / quotient negative
  logic              rneg_q, rneg_d;   // remainder negative (dividend sign)
  logic              spec_q, spec_d;   // acc already holds the final divide values
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;     // mul: product; div: {remainder, quotient}
  logic [XLEN-1:0]   result_q, result_d;

  // ---------------------------------------------------------------------------
  // Operand decode for the op presented in IDLE
  // ---------------------------------------------------------------------------
  logic            a_sgn_op, b_sgn_op;
  logic [XLEN-1:0] a_ext, b_ext;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] most_neg;
  logic            div_zero, div_ovf, special;
  logic            accept;

  always_comb begin
    a_sgn_op = op_a_signed(op);
    b_sgn_op = op_b_signed(op);

    // Word ops: extend the low 32 bits according to signedness so the rest
    // of the datapath sees an ordinary XLEN-bit value.
    a_ext = a;
    b_ext = b;
    if (word) begin
      a_ext       = {XLEN{a_sgn_op & a[31]}};
      a_ext[31:0] = a[31:0];
      b_ext       = {XLEN{b_sgn_op & b[31]}};
      b_ext[31:0] = b[31:0];
    end

    a_neg = a_sgn_op & a_ext[XLEN-1];
    b_neg = b_sgn_op & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;

    // Most-negative N-bit value, as seen after extension.
    most_neg           = '0;
    most_neg[XLEN-1]   = 1'b1;
    if (word) begin
      most_neg       = '1;
      most_neg[30:0] = '0;
    end

    div_zero = (b_ext == '0);
    div_ovf  = op_b_signed(op) && (a_ext == most_neg) && (b_ext == '1);
    special  = op_is_div(op) && (div_zero || div_ovf);

    accept   = (state_q == S_IDLE) && valid_in && !flush;
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC: begin
        if (flush)              state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
  logic          qbit;

  always_comb begin
    op_d   = op_q;
    word_d = word_q;
    ma_d   = ma_q;
    mb_d   = mb_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    spec_d = spec_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    trial  = '0;
    diff   = '0;
    qbit   = 1'b0;

    if (accept) begin
      op_d   = op;
      word_d = word;
      ma_d   = a_mag;
      mb_d   = b_mag;
      qneg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
      spec_d = special;
      cnt_d  = word ? CW'(31) : CW'(XLEN - 1);
      if (op_is_div(op) && div_zero)
        acc_d = {a_ext, {XLEN{1'b1}}};
      else if (op_is_div(op) && div_ovf)
        acc_d = {{XLEN{1'b0}}, a_ext};
      else
        acc_d = '0;
    end else if (state_q == S_CALC && !flush) begin
      cnt_d = cnt_q - CW'(1);
      if (op_is_div(op_q)) begin
        // Bring down the next dividend bit, MSB first.
        trial = {acc_q[2*XLEN-1:XLEN], ma_q[cnt_q]};
        diff  = trial - {1'b0, mb_q};
        qbit  = (trial >= {1'b0, mb_q});
        acc_d = {(qbit ? diff[XLEN-1:0] : trial[XLEN-1:0]),
                 acc_q[XLEN-2:0], qbit};
      end else begin
        // MSB-first shift-add so N can vary without moving the product.
        acc_d = (acc_q << 1) +
                (mb_q[cnt_q] ? {{XLEN{1'b0}}, ma_q} : {2*XLEN{1'b0}});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Final result selection (meaningful in DONE)
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, sel, fin;

  always_comb begin
    prod = qneg_q ? -acc_q : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    if (!spec_q) begin
      quo = qneg_q ? -quo : quo;
      rem = rneg_q ? -rem : rem;
    end

    sel = '0;
    if (op_is_div(op_q)) begin
      sel = op_is_rem(op_q) ? rem : quo;
    end else if (word_q) begin
      sel[31:0] = op_is_high(op_q) ? prod[63:32] : prod[31:0];
    end else begin
      sel = op_is_high(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

    fin = sel;
    if (word_q) begin
      fin       = {XLEN{sel[31]}};
      fin[31:0] = sel[31:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: a flush in DONE suppresses both the pulse and the result update.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall    = accept || ((state_q == S_CALC) && !flush);
    done     = (state_q == S_DONE) && !flush;
    result   = done ? fin : result_q;
    result_d = result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= MD_MUL;
      word_q   <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      spec_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      spec_q   <= spec_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected result and
// latency; a negedge monitor pops and checks on every done pulse.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  muldiv_op_t  op;
  logic        word;
  logic [63:0] a, b;
  logic        flush;
  logic        stall, done;
  logic [63:0] result;

  muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .op(op), .word(word),
    .a(a), .b(b), .flush(flush), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: latency counted from the accept cycle (valid_in & stall, idle).
  bit   busy = 0;
  int   lat  = 0;
  int   scnt = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!reset) begin
      busy = 0;
    end else begin
      if (busy) begin
        lat++;
        if (stall) scnt++;
      end
      if (done) begin
        if (!busy || sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: result=%h", result);
        end else begin
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("latency", 64'(lat + 1), 64'(e.lat));
          chk("stall_cycles", 64'(scnt), 64'(e.lat - 1));
        end
        busy = 0;
      end else if (busy && flush) begin
        chk("flush_stall_mon", {63'd0, stall}, 64'd0);
        busy = 0;
      end else if (!busy && valid_in && stall) begin
        busy = 1;
        lat  = 0;
        scnt = 1;
      end
    end
  end

  // Caller is at posedge+1 with the DUT idle; returns at posedge+1 after accept.
  task automatic issue(input muldiv_op_t o, input logic w, input logic [63:0] aa,
                       input logic [63:0] bb, input bit push,
                       input logic [63:0] er, input int el);
    exp_t x;
    if (push) begin
      x.res = er;
      x.lat = el;
      sb_q.push_back(x);
    end
    op = o; word = w; a = aa; b = bb;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout: no done within %0d cycles", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input muldiv_op_t o, input logic w, input logic [63:0] aa,
                     input logic [63:0] bb, input logic [63:0] er, input int el);
    issue(o, w, aa, bb, 1'b1, er, el);
    wait_done(200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; valid_in = 1'b0; flush = 1'b0;
    op = MD_MUL; word = 1'b0; a = '0; b = '0;

    @(negedge clk);
    chk("reset_done",   {63'd0, done},  64'd0);
    chk("reset_stall",  {63'd0, stall}, 64'd0);
    chk("reset_result", result,         64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run(MD_MUL,    1'b0, 64'd7,                  -64'sd3,               64'hFFFF_FFFF_FFFF_FFEB, 66);
    run(MD_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run(MD_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run(MD_DIV,    1'b0, -64'sd7,                64'd2,                 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run(MD_REM,    1'b0, -64'sd7,                64'd2,                 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run(MD_DIVU,   1'b0, 64'd100,                64'd7,                 64'd14,                  66);
    run(MD_REMU,   1'b0, 64'd100,                64'd7,                 64'd2,                   66);
    run(MD_DIVU,   1'b0, 64'd100,                64'd0,                 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run(MD_DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2);
    run(MD_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   2);
    run(MD_DIV,    1'b1, 64'h0000_0001_8000_0000, 64'd1,                 64'hFFFF_FFFF_8000_0000, 34);
    run(MD_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFE, 34);
    run(MD_REM,    1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_9ABC_DEF0, 2);

    // valid_in together with flush in IDLE: must not be accepted.
    op = MD_MUL; word = 1'b0; a = 64'd3; b = 64'd3;
    valid_in = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Flush at CALC cycle 10: no done, result keeps the last REMW value.
    issue(MD_MUL, 1'b0, 64'd11, 64'd13, 1'b0, 64'd0, 0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_calc_stall", {63'd0, stall}, 64'd0);
    chk("flush_calc_done",  {63'd0, done},  64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_result_kept", result, 64'hFFFF_FFFF_9ABC_DEF0);
    run(MD_MUL, 1'b0, 64'd5, 64'd6, 64'd30, 66);

    // Reset mid-CALC.
    issue(MD_MUL, 1'b0, 64'd3, 64'd4, 1'b0, 64'd0, 0);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_done",   {63'd0, done},  64'd0);
    chk("midreset_stall",  {63'd0, stall}, 64'd0);
    chk("midreset_result", result,         64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: second op raised during DONE, accepted the next cycle.
    issue(MD_MUL, 1'b0, 64'd1, 64'd2, 1'b1, 64'd2, 66);
    begin
      bit seen = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1;
          break;
        end
      end
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL b2b_timeout: first op never completed");
      end
    end
    chk("b2b_done_stall", {63'd0, stall}, 64'd0);
    #1;
    begin
      exp_t x;
      x.res = 64'd6;
      x.lat = 66;
      sb_q.push_back(x);
    end
    op = MD_MUL; word = 1'b0; a = 64'd2; b = 64'd3;
    valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_accept_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    wait_done(200);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
